// File: rtl/l2_cache_pkg.sv
// Shared types for the L2 cache controller: FSM state encoding, mux select
// encodings and the bundle of control strobes driven toward the arrays/pmem.
package l2_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_FILL      = 3'd3,
        ST_REREAD    = 3'd4
    } l2_ctrl_state_t;

    localparam logic DATA_SEL_MEM    = 1'b0;  // upstream write data
    localparam logic DATA_SEL_PMEM   = 1'b1;  // pmem fill data
    localparam logic ADDR_SEL_REQ    = 1'b0;  // request address
    localparam logic ADDR_SEL_VICTIM = 1'b1;  // stored tag + index

    typedef struct packed {
        logic mem_resp;
        logic array_read;
        logic data_load;
        logic tag_load;
        logic valid_load;
        logic dirty_load;
        logic dirty_in;
        logic data_sel;
        logic addr_sel;
        logic pmem_read;
        logic pmem_write;
    } l2_ctrl_out_t;

endpackage

// File: rtl/l2_cache_control_if.sv
// Controller-facing bus: upstream handshake, array strobes, pmem handshake, stats.
// master = the controller, slave = the datapath/environment around it.
interface l2_cache_control_if #(parameter int CNT_W = 16);
    logic             mem_read;
    logic             mem_write;
    logic             mem_resp;
    logic             hit;
    logic             dirty;
    logic             array_read;
    logic             data_load;
    logic             tag_load;
    logic             valid_load;
    logic             dirty_load;
    logic             dirty_in;
    logic             data_sel;
    logic             addr_sel;
    logic             pmem_read;
    logic             pmem_write;
    logic             pmem_resp;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport master (
        input  mem_read, mem_write, hit, dirty, pmem_resp,
        output mem_resp, array_read, data_load, tag_load, valid_load, dirty_load,
               dirty_in, data_sel, addr_sel, pmem_read, pmem_write,
               hit_count, miss_count
    );

    modport slave (
        output mem_read, mem_write, hit, dirty, pmem_resp,
        input  mem_resp, array_read, data_load, tag_load, valid_load, dirty_load,
               dirty_in, data_sel, addr_sel, pmem_read, pmem_write,
               hit_count, miss_count
    );
endinterface

// File: rtl/l2_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module l2_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != {CNT_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/l2_cache_control.sv
// L2 cache controller FSM: hit service, dirty-victim writeback, fill and reread,
// plus hit/miss statistics.
module l2_cache_control
    import l2_cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_cache_control_if.master bus
);

    l2_ctrl_state_t state, state_nxt;
    l2_ctrl_out_t   out_c;
    logic           refilled;
    logic           hit_inc, miss_inc;

    always_comb begin
        out_c     = '0;
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.mem_read || bus.mem_write) begin
                    out_c.array_read = 1'b1;
                    state_nxt        = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (bus.hit) begin
                    out_c.mem_resp = 1'b1;
                    // write wins over read when both are asserted
                    if (bus.mem_write) begin
                        out_c.data_load  = 1'b1;
                        out_c.dirty_load = 1'b1;
                        out_c.dirty_in   = 1'b1;
                        out_c.data_sel   = DATA_SEL_MEM;
                    end
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = bus.dirty ? ST_WRITEBACK : ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                out_c.pmem_write = 1'b1;
                out_c.addr_sel   = ADDR_SEL_VICTIM;
                if (bus.pmem_resp) state_nxt = ST_FILL;
            end
            ST_FILL: begin
                out_c.pmem_read = 1'b1;
                out_c.addr_sel  = ADDR_SEL_REQ;
                if (bus.pmem_resp) begin
                    out_c.data_load  = 1'b1;
                    out_c.tag_load   = 1'b1;
                    out_c.valid_load = 1'b1;
                    out_c.dirty_load = 1'b1;
                    out_c.dirty_in   = 1'b0;
                    out_c.data_sel   = DATA_SEL_PMEM;
                    state_nxt        = ST_REREAD;
                end
            end
            ST_REREAD: begin
                out_c.array_read = 1'b1;
                state_nxt        = ST_COMPARE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are Mealy on held inputs, so mask them while reset is asserted.
    l2_ctrl_out_t out_g;
    assign out_g = rst_n ? out_c : '0;

    assign bus.mem_resp   = out_g.mem_resp;
    assign bus.array_read = out_g.array_read;
    assign bus.data_load  = out_g.data_load;
    assign bus.tag_load   = out_g.tag_load;
    assign bus.valid_load = out_g.valid_load;
    assign bus.dirty_load = out_g.dirty_load;
    assign bus.dirty_in   = out_g.dirty_in;
    assign bus.data_sel   = out_g.data_sel;
    assign bus.addr_sel   = out_g.addr_sel;
    assign bus.pmem_read  = out_g.pmem_read;
    assign bus.pmem_write = out_g.pmem_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            refilled <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_FILL && bus.pmem_resp)
                refilled <= 1'b1;
            else if (state_nxt == ST_IDLE)
                refilled <= 1'b0;
        end
    end

    // The post-refill COMPARE hit belongs to the miss already counted.
    assign hit_inc  = (state == ST_COMPARE) &&  bus.hit && !refilled;
    assign miss_inc = (state == ST_COMPARE) && !bus.hit;

    l2_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hit_inc),
        .count (bus.hit_count)
    );

    l2_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (miss_inc),
        .count (bus.miss_count)
    );

endmodule

// File: tb/tb_l2_cache_control.sv
// Directed bench for l2_cache_control; narrow counters so saturation is reachable.
module tb_l2_cache_control;

    localparam logic [10:0] MR = 11'h400, AR = 11'h200, DL = 11'h100, TL = 11'h080,
                            VL = 11'h040, YL = 11'h020, DI = 11'h010, DS = 11'h008,
                            AS = 11'h004, PR = 11'h002, PW = 11'h001;
    localparam logic [10:0] FILL_LD = PR | DL | TL | VL | YL | DS;
    localparam logic [10:0] WR_HIT  = MR | DL | YL | DI;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    l2_cache_control_if #(.CNT_W(2)) bus ();

    l2_cache_control #(.CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    function automatic logic [10:0] outs();
        return {bus.mem_resp, bus.array_read, bus.data_load, bus.tag_load,
                bus.valid_load, bus.dirty_load, bus.dirty_in, bus.data_sel,
                bus.addr_sel, bus.pmem_read, bus.pmem_write};
    endfunction

    task automatic clear_inputs();
        bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.dirty = 0; bus.pmem_resp = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        bus.mem_read = 1; bus.hit = 1;
        #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL reset_outs got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.hit_count !== 2'd0 || bus.miss_count !== 2'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count); end
        next_cyc();
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL reset_held got %b exp %b", outs(), 11'h0); end
        clear_inputs();
    endtask

    task automatic test_read_hit();
        do_reset();
        bus.mem_read = 1; bus.hit = 1; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL rd_hit_c0 got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== MR) begin errors++; $display("FAIL rd_hit_c1 got %b exp %b", outs(), MR); end
        next_cyc(); bus.mem_read = 0; bus.hit = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL rd_hit_idle got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.hit_count !== 2'd1 || bus.miss_count !== 2'd0) begin errors++; $display("FAIL rd_hit_counts got %0d/%0d exp 1/0", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_clean_miss();
        logic [10:0] exp;
        do_reset();
        bus.mem_read = 1; bus.hit = 0; bus.dirty = 0; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL cm_c0 got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL cm_compare got %b exp %b", outs(), 11'h0); end
        for (int k = 0; k < 3; k++) begin
            next_cyc(); bus.pmem_resp = (k == 2); #1;
            exp = (k == 2) ? FILL_LD : PR;
            checks++; if (outs() !== exp) begin errors++; $display("FAIL cm_fill%0d got %b exp %b", k, outs(), exp); end
        end
        checks++; if (bus.miss_count !== 2'd1) begin errors++; $display("FAIL cm_miss_inc got %0d exp 1", bus.miss_count); end
        next_cyc(); bus.pmem_resp = 0; bus.hit = 1; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL cm_reread got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== MR) begin errors++; $display("FAIL cm_resp got %b exp %b", outs(), MR); end
        next_cyc(); bus.mem_read = 0; bus.hit = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL cm_idle got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.hit_count !== 2'd0 || bus.miss_count !== 2'd1) begin errors++; $display("FAIL cm_counts got %0d/%0d exp 0/1", bus.hit_count, bus.miss_count); end
    endtask

    task automatic test_dirty_write_miss();
        do_reset();
        bus.mem_write = 1; bus.hit = 0; bus.dirty = 1; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL dw_c0 got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL dw_compare got %b exp %b", outs(), 11'h0); end
        for (int k = 0; k < 2; k++) begin
            next_cyc(); bus.pmem_resp = (k == 1); #1;
            checks++; if (outs() !== (PW | AS)) begin errors++; $display("FAIL dw_wb%0d got %b exp %b", k, outs(), PW | AS); end
        end
        next_cyc(); bus.pmem_resp = 1; bus.dirty = 0; #1;
        checks++; if (outs() !== FILL_LD) begin errors++; $display("FAIL dw_fill got %b exp %b", outs(), FILL_LD); end
        next_cyc(); bus.pmem_resp = 0; bus.hit = 1; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL dw_reread got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== WR_HIT) begin errors++; $display("FAIL dw_wr_hit got %b exp %b", outs(), WR_HIT); end
        next_cyc(); bus.mem_write = 0; bus.hit = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL dw_idle got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.hit_count !== 2'd0 || bus.miss_count !== 2'd1) begin errors++; $display("FAIL dw_counts got %0d/%0d exp 0/1", bus.hit_count, bus.miss_count); end
        // stray pmem_resp in IDLE must not move the FSM
        bus.pmem_resp = 1; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL stray_resp0 got %b exp %b", outs(), 11'h0); end
        next_cyc(); bus.pmem_resp = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL stray_resp1 got %b exp %b", outs(), 11'h0); end
    endtask

    task automatic test_back_to_back_saturation();
        logic [1:0] exp;
        do_reset();
        bus.mem_read = 1; bus.hit = 1;
        for (int i = 0; i < 5; i++) begin
            next_cyc();
            checks++; if (outs() !== MR) begin errors++; $display("FAIL sat_resp%0d got %b exp %b", i, outs(), MR); end
            next_cyc();
            exp = (i < 3) ? 2'(i + 1) : 2'd3;
            checks++; if (bus.hit_count !== exp) begin errors++; $display("FAIL sat_count%0d got %0d exp %0d", i, bus.hit_count, exp); end
        end
        clear_inputs();
    endtask

    task automatic test_read_write_both();
        do_reset();
        bus.mem_read = 1; bus.mem_write = 1; bus.hit = 1; #1;
        checks++; if (outs() !== AR) begin errors++; $display("FAIL both_c0 got %b exp %b", outs(), AR); end
        next_cyc();
        checks++; if (outs() !== WR_HIT) begin errors++; $display("FAIL both_write got %b exp %b", outs(), WR_HIT); end
        next_cyc(); clear_inputs(); #1;
        checks++; if (bus.hit_count !== 2'd1) begin errors++; $display("FAIL both_count got %0d exp 1", bus.hit_count); end
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        bus.mem_read = 1; bus.hit = 0; bus.dirty = 0; #1;
        next_cyc();
        next_cyc();
        checks++; if (outs() !== PR) begin errors++; $display("FAIL rf_fill got %b exp %b", outs(), PR); end
        #2 rst_n = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL rf_async got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.miss_count !== 2'd0) begin errors++; $display("FAIL rf_cnt_clr got %0d exp 0", bus.miss_count); end
        bus.mem_read = 0;
        next_cyc();
        next_cyc(); rst_n = 1; bus.pmem_resp = 1; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL rf_late_resp got %b exp %b", outs(), 11'h0); end
        next_cyc(); bus.pmem_resp = 0; #1;
        checks++; if (outs() !== 11'h0) begin errors++; $display("FAIL rf_idle got %b exp %b", outs(), 11'h0); end
        checks++; if (bus.hit_count !== 2'd0 || bus.miss_count !== 2'd0) begin errors++; $display("FAIL rf_counts got %0d/%0d exp 0/0", bus.hit_count, bus.miss_count); end
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_clean_miss();
        test_dirty_write_miss();
        test_back_to_back_saturation();
        test_read_write_both();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2_cache_control.md
L2_CACHE_CONTROL -- requirements
Module: l2_cache_control

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the hit and miss statistic counters.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port mem_read  input  1  upstream read request, held until mem_resp.
REQ-005 SHALL have port mem_write  input  1  upstream write request, held until mem_resp.
REQ-006 SHALL have port mem_resp  output  1  one-cycle completion pulse to upstream.
REQ-007 SHALL have port hit  input  1  tag match AND valid for the indexed line; sampled only in COMPARE.
REQ-008 SHALL have port dirty  input  1  dirty bit of the indexed line; sampled only in COMPARE.
REQ-009 SHALL have port array_read  output  1  read strobe to all L2 arrays; registered read, data valid next cycle.
REQ-010 SHALL have ports data_load, tag_load, valid_load, dirty_load  output  1 each  array write strobes.
REQ-011 SHALL have port dirty_in  output  1  value written to the dirty array.
REQ-012 SHALL have port data_sel  output  1  data array source: 0 upstream write data, 1 pmem fill data.
REQ-013 SHALL have port addr_sel  output  1  pmem address: 0 request address, 1 victim address (stored tag + index).
REQ-014 SHALL have ports pmem_read, pmem_write  output  1 each  downstream requests, held until pmem_resp.
REQ-015 SHALL have port pmem_resp  input  1  downstream one-cycle completion.
REQ-016 SHALL have ports hit_count, miss_count  output  CNT_W each  saturating statistics.

Function
REQ-017 SHALL implement states IDLE, COMPARE, WRITEBACK, FILL, REREAD; all outputs not named as asserted in a state SHALL be 0 in that state.
REQ-018 IDLE: on mem_read or mem_write, assert array_read, go COMPARE; otherwise stay.
REQ-019 COMPARE, hit, read: assert mem_resp, go IDLE.
REQ-020 COMPARE, hit, write: assert data_load, dirty_load, dirty_in=1, data_sel=0, mem_resp; go IDLE.
REQ-021 COMPARE, miss, dirty=1: go WRITEBACK; miss, dirty=0: go FILL.
REQ-022 WRITEBACK: pmem_write=1, addr_sel=1; on pmem_resp go FILL.
REQ-023 FILL: pmem_read=1, addr_sel=0; on pmem_resp assert data_load, tag_load, valid_load, dirty_load, dirty_in=0, data_sel=1; go REREAD.
REQ-024 REREAD: assert array_read, go COMPARE; the following COMPARE SHALL be a hit.
REQ-025 mem_resp SHALL occur exactly once per request; hit-path latency is 2 cycles from request in IDLE to mem_resp.
REQ-026 Simultaneous mem_read and mem_write SHALL be treated as a write.
REQ-027 Request withdrawn mid-operation SHALL NOT abort the sequence; an in-flight WRITEBACK/FILL completes.
REQ-028 pmem_resp outside WRITEBACK/FILL SHALL be ignored.
REQ-029 A refilled flag SHALL be set on the FILL-to-REREAD transition and cleared on return to IDLE; hit_count SHALL increment on a COMPARE hit only when the flag is clear; miss_count SHALL increment on each COMPARE miss.
REQ-030 Counters SHALL saturate at 2**CNT_W-1 and never wrap.

Reset
REQ-031 rst_n low SHALL force IDLE, clear the refilled flag, and zero both counters and all outputs immediately, without waiting for clk, including mid-WRITEBACK/FILL.
REQ-032 First transition after reset release SHALL occur on the first rising clk edge with rst_n high.

Structure
REQ-033 Package l2_cache_pkg SHALL hold the state enum l2_ctrl_state_t and the data_sel/addr_sel encodings as named constants.
REQ-034 Counters SHALL be two instances of sub-module l2_sat_counter (params CNT_W; ports clk, rst_n, inc, count).
REQ-035 Next-state/output logic SHALL be combinational; state and counters SHALL be flops only.

Verification
REQ-036 Read hit: mem_read=1 in IDLE, hit=1 -> array_read cycle 0, mem_resp cycle 1, hit_count=1.
REQ-037 Clean read miss: hit=0, dirty=0, pmem_resp after 3 cycles -> pmem_read held 3 cycles, loads with data_sel=1 and dirty_in=0, REREAD, mem_resp; miss_count=1, hit_count=0.
REQ-038 Dirty write miss: hit=0, dirty=1 -> pmem_write with addr_sel=1 until pmem_resp, then FILL, then write hit with dirty_in=1, a single mem_resp.
REQ-039 Saturation: CNT_W=2, 5 read hits -> hit_count stays 3.
REQ-040 Reset mid-FILL: rst_n low while pmem_read=1 -> pmem_read and all outputs 0 before the next clk edge; a later pmem_resp is ignored.
REQ-041 Both mem_read and mem_write high with hit=1 -> write path (data_load=1, dirty_in=1).
